multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//   Sequences the shared multi-cycle multdiv unit for the execute stage.
//   - Turns the level-decoded mul/div in X into one start pulse.
//   - Holds the pipeline stall until the unit reports ready or a watchdog expires.
//   - Captures the result and exception code.
//   - Handles a flush during an operation by draining the in-flight operation
//     before it accepts a new one.
// PARAMETERS
//   WIDTH    32  datapath width of multdiv result
//   TIMEOUT  64  max cycles in BUSY before watchdog abort (>=2)
// PORTS
//   clock          in   1      master clock; all state updates on posedge
//   reset          in   1      synchronous, active-high reset
//   x_mul          in   1      X-stage insn is mul (level, held while stalled)
//   x_div          in   1      X-stage insn is div (level, held while stalled)
//   flush          in   1      X-stage insn squashed (branch/jump taken)
//   md_ready       in   1      multdiv data_resultRDY
//   md_result      in   WIDTH  multdiv data_result
//   md_exception   in   1      multdiv data_exception
//   ctrl_MULT      out  1      one-cycle start pulse to multdiv (mult)
//   ctrl_DIV       out  1      one-cycle start pulse to multdiv (div)
//   stall          out  1      freeze PC/FD/DX/XM/MW latches
//   result         out  WIDTH  captured result, valid with result_valid
//   result_valid   out  1      high exactly one cycle (DONE)
//   exc_code       out  3      4=mul exc, 5=div exc, 0=none; valid with result_valid
//   timeout        out  1      sticky; set on watchdog abort, cleared by reset only
// BEHAVIOUR
//   States: IDLE, ISSUE, BUSY, DONE, DRAIN. Reset -> IDLE.
//   Reset values of registered outputs:
//     ctrl_MULT=0, ctrl_DIV=0, result=0, result_valid=0, exc_code=0, timeout=0.
//   op = x_mul|x_div. If both are high, mul wins.
//   stall is combinational:
//     stall = op & ~flush & ~reset & (state != DONE)
//           | (state == DRAIN & op & ~reset).
//   IDLE:
//     - op & ~flush: latch kind (mul/div), go to ISSUE.
//     - Otherwise stay in IDLE.
//   ISSUE:
//     - ctrl_MULT or ctrl_DIV is registered high for this cycle only; count=0.
//     - flush -> DRAIN; otherwise -> BUSY.
//   BUSY:
//     - count increments each cycle.
//     - md_ready: result<=md_result; exc_code<=md_exception ? (mul?4:5) : 0;
//       go to DONE.
//     - count==TIMEOUT-1 without ready: result<=0; exc_code<=(mul?4:5);
//       timeout<=1; go to DONE.
//     - flush without ready -> DRAIN.
//   DONE:
//     - result_valid=1 and stall=0 for one cycle, so X advances; go to IDLE.
//     - op and flush are ignored in this cycle.
//   DRAIN:
//     - Wait for md_ready or watchdog; the result is discarded, result_valid
//       stays 0, and timeout is not set.
//     - Then go to IDLE. A new op arriving during DRAIN is stalled and not issued.
//   Latency: op seen at cycle 0 -> pulse at cycle 1 -> result_valid at
//     ready_cycle+1. Minimum total is 3 cycles.
//   Back-to-back ops: DONE->IDLE->ISSUE, so the second pulse comes 2 cycles
//     after the first result_valid.
//   result and exc_code hold their values until the next capture.
//   Ready while in IDLE or ISSUE is ignored (spurious).
//   Reset mid-operation: immediate return to IDLE; pulses drop the same cycle.
// TESTING
//   1. mul with A=7, B=9, md_ready at cycle 17, md_result=63 ->
//      ctrl_MULT high only at cycle 1; stall high for cycles 0..17;
//      result_valid, result=63, exc_code=0 at cycle 18.
//   2. div by 0, md_exception=1 with ready at cycle 20 -> exc_code=5,
//      result_valid=1 at cycle 21; ctrl_DIV pulses exactly once.
//   3. flush at cycle 5 of a mul -> stall drops at cycle 5. A new div presented
//      at cycle 6 is stalled until the old md_ready at cycle 17. Then
//      ctrl_DIV pulses at cycle 19 and result_valid stays low for the flushed mul.
//   4. md_ready never asserted -> at BUSY count 63, result=0, exc_code=4,
//      timeout=1 sticky, stall releases.
//   5. Two consecutive muls, each with 16-cycle latency -> two distinct pulses,
//      two result_valid cycles, no lost or duplicate result.
//   6. reset asserted during BUSY -> all outputs at reset values the next cycle;
//      a fresh op restarts from ISSUE.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// Issues one start pulse per mul/div in X, stalls the pipeline until the shared
// multdiv unit answers (or a watchdog fires), and drains squashed operations.
module multdiv_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_mul,
  input  logic             x_div,
  input  logic             flush,
  input  logic             md_ready,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       exc_code,
  output logic             timeout
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t           state_q;
  logic             kind_mul_q;
  logic [CW-1:0]    count_q;
  logic             ctrl_mult_q;
  logic             ctrl_div_q;
  logic [WIDTH-1:0] result_q;
  logic             result_valid_q;
  logic [2:0]       exc_code_q;
  logic             timeout_q;

  logic             op;
  logic             count_last;
  logic [2:0]       kind_code;

  assign op         = x_mul | x_div;
  assign count_last = (count_q == COUNT_LAST);
  assign kind_code  = kind_mul_q ? 3'd4 : 3'd5;

  // A new op is held back while an old one drains, but DONE must let X advance.
  assign stall = (op & ~flush & ~reset & (state_q != S_DONE))
               | ((state_q == S_DRAIN) & op & ~reset);

  // Pulses are masked by reset so an aborted issue never reaches the unit.
  assign ctrl_MULT    = ctrl_mult_q & ~reset;
  assign ctrl_DIV     = ctrl_div_q & ~reset;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign exc_code     = exc_code_q;
  assign timeout      = timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      kind_mul_q     <= 1'b0;
      count_q        <= '0;
      ctrl_mult_q    <= 1'b0;
      ctrl_div_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      exc_code_q     <= 3'd0;
      timeout_q      <= 1'b0;
    end else begin
      ctrl_mult_q    <= 1'b0;
      ctrl_div_q     <= 1'b0;
      result_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op && !flush) begin
            kind_mul_q  <= x_mul;
            ctrl_mult_q <= x_mul;
            ctrl_div_q  <= ~x_mul;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          count_q <= '0;
          state_q <= flush ? S_DRAIN : S_BUSY;
        end
        S_BUSY: begin
          count_q <= count_q + CW'(1);
          if (md_ready) begin
            result_q       <= md_result;
            exc_code_q     <= md_exception ? kind_code : 3'd0;
            result_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end else if (count_last) begin
            result_q       <= '0;
            exc_code_q     <= kind_code;
            timeout_q      <= 1'b1;
            result_valid_q <= 1'b1;
            state_q        <= S_DONE;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          // The unit is still busy with the squashed op; wait it out silently.
          count_q <= count_q + CW'(1);
          if (md_ready || count_last) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scenario bench for multdiv_sequencer: per-cycle stall/pulse checks plus a
// scoreboard of expected results popped whenever result_valid fires.
module tb_multdiv_sequencer;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;

  logic             clock;
  logic             reset;
  logic             x_mul;
  logic             x_div;
  logic             flush;
  logic             md_ready;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [2:0]       exc_code;
  logic             timeout;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [2:0]       exc;
  } exp_t;

  exp_t sb[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   mul_pulses = 0;
  int   div_pulses = 0;

  multdiv_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .x_mul        (x_mul),
    .x_div        (x_div),
    .flush        (flush),
    .md_ready     (md_ready),
    .md_result    (md_result),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid),
    .exc_code     (exc_code),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard side: every result_valid must match the oldest expected entry.
  always @(negedge clock) begin
    if (ctrl_MULT) mul_pulses++;
    if (ctrl_DIV)  div_pulses++;
    if (!reset && result_valid === 1'b1) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected result=%h exc=%0d but no result expected", result, exc_code);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res || exc_code !== e.exc)
          $display("FAIL sb_result got result=%h exc=%0d expected result=%h exc=%0d",
                   result, exc_code, e.res, e.exc);
        else begin
          pass_cnt++;
          $display("txn result=%h exc=%0d", result, exc_code);
        end
      end
    end
  end

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s cycle=%0d got %h expected %h", name, c, got, exp);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    x_mul = 0; x_div = 0; flush = 0; md_ready = 0; md_result = '0; md_exception = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    total_cnt++;
    if ({ctrl_MULT, ctrl_DIV, stall, result_valid, timeout} !== 5'b0 || result !== '0 || exc_code !== 3'd0)
      $display("FAIL reset_state got ctl=%b%b stall=%b rv=%b tmo=%b result=%h exc=%0d expected all 0",
               ctrl_MULT, ctrl_DIV, stall, result_valid, timeout, result, exc_code);
    else pass_cnt++;
    @(posedge clock); #1;
  endtask

  // One isolated op; ready_at < 0 means the unit never answers.
  task automatic run_op(input bit mul, input int ready_at, input logic [WIDTH-1:0] res,
                        input bit exc, input string name);
    int done_c;
    exp_t e;
    done_c = (ready_at >= 0) ? ready_at + 1 : TIMEOUT + 2;
    e.res  = (ready_at >= 0) ? res : '0;
    e.exc  = (ready_at < 0 || exc) ? (mul ? 3'd4 : 3'd5) : 3'd0;
    sb.push_back(e);
    for (int c = 0; c <= done_c + 1; c++) begin
      x_mul        = mul && (c <= done_c);
      x_div        = !mul && (c <= done_c);
      flush        = 0;
      md_ready     = (c == ready_at) || (c == 1);
      md_result    = (c == ready_at) ? res : 32'hDEAD_BEEF;
      md_exception = (c == ready_at) ? exc : 1'b1;
      @(negedge clock);
      chk({name, "_stall"}, c, 32'(stall), 32'(c < done_c));
      chk({name, "_pulse"}, c, {30'd0, ctrl_MULT, ctrl_DIV},
          {30'd0, mul && c == 1, !mul && c == 1});
      chk({name, "_rv"}, c, 32'(result_valid), 32'(c == done_c));
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_mul();
    run_op(1, 17, 32'd63, 0, "mul");
  endtask

  task automatic test_div_exc();
    div_pulses = 0;
    run_op(0, 20, 32'hFFFF_FFFF, 1, "divexc");
    chk("div_pulse_count", 0, 32'(div_pulses), 32'd1);
  endtask

  task automatic test_flush();
    exp_t e;
    for (int c = 0; c <= 27; c++) begin
      x_mul        = (c <= 5);
      flush        = (c == 5);
      x_div        = (c >= 6) && (c <= 26);
      md_ready     = (c == 17) || (c == 25);
      md_result    = (c == 17) ? 32'h1111_1111 : 32'h0000_0042;
      md_exception = 0;
      if (c == 6) begin
        e.res = 32'h0000_0042; e.exc = 3'd0;
        sb.push_back(e);
      end
      @(negedge clock);
      chk("flush_stall", c, 32'(stall), 32'((c <= 4) || (c >= 6 && c <= 25)));
      chk("flush_pulse", c, {30'd0, ctrl_MULT, ctrl_DIV}, {30'd0, c == 1, c == 19});
      chk("flush_rv", c, 32'(result_valid), 32'(c == 26));
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    run_op(1, -1, '0, 0, "tmo");
    @(negedge clock);
    chk("timeout_set", 0, 32'(timeout), 32'd1);
    @(posedge clock); #1;
    run_op(0, 4, 32'h0000_0005, 0, "aftertmo");
    @(negedge clock);
    chk("timeout_sticky", 0, 32'(timeout), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.res = 32'd100; e.exc = 3'd0; sb.push_back(e);
    e.res = 32'd200; e.exc = 3'd0; sb.push_back(e);
    for (int c = 0; c <= 38; c++) begin
      x_mul        = (c <= 37);
      md_ready     = (c == 17) || (c == 36);
      md_result    = (c == 17) ? 32'd100 : (c == 36) ? 32'd200 : 32'hBAD0_BAD0;
      md_exception = 0;
      @(negedge clock);
      chk("b2b_stall", c, 32'(stall), 32'((c <= 17) || (c >= 19 && c <= 36)));
      chk("b2b_pulse", c, {30'd0, ctrl_MULT, ctrl_DIV}, {30'd0, c == 1 || c == 20, 1'b0});
      chk("b2b_rv", c, 32'(result_valid), 32'(c == 18 || c == 37));
      @(posedge clock); #1;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int c = 0; c <= 14; c++) begin
      x_mul     = (c <= 13);
      reset     = (c == 8);
      md_ready  = (c == 12);
      md_result = (c == 12) ? 32'd77 : 32'hCAFE_0000;
      if (c == 9) begin
        e.res = 32'd77; e.exc = 3'd0;
        sb.push_back(e);
      end
      @(negedge clock);
      chk("rstmid_stall", c, 32'(stall), 32'((c <= 7) || (c >= 9 && c <= 12)));
      chk("rstmid_pulse", c, {30'd0, ctrl_MULT, ctrl_DIV}, {30'd0, c == 1 || c == 10, 1'b0});
      chk("rstmid_rv", c, 32'(result_valid), 32'(c == 13));
      if (c == 9) begin
        chk("rstmid_result", c, result, 32'd0);
        chk("rstmid_exc", c, 32'(exc_code), 32'd0);
        chk("rstmid_timeout", c, 32'(timeout), 32'd0);
      end
      @(posedge clock); #1;
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clock); #1;
    test_reset();
    test_mul();
    test_div_exc();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (3) @(posedge clock);
    #1;
    chk("sb_drained", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
